// File: rtl/alu_ctrl_idex.sv
// alu_ctrl_idex: ID-stage decode into ALU operation and datapath controls,
// ID/EX pipeline register, EX-stage BEQ/BNE resolution with front-end flush
// request, and a taken-branch performance counter.
module alu_ctrl_idex #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             stall,
    input  logic             alu_zero,
    output logic             ex_valid,
    output logic [2:0]       ex_aluoperation,
    output logic             ex_alusrc,
    output logic [XLEN-1:0]  ex_imm,
    output logic [XLEN-1:0]  ex_pc,
    output logic [4:0]       ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             branch_taken,
    output logic [XLEN-1:0]  branch_target,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] taken_count
);

    // Major opcodes recognised by this decoder.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 encodings.
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    // funct7 encodings for register-register operations.
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation codes driven to EX.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Contents of the ID/EX pipeline register.
    typedef struct packed {
        logic            valid;
        logic [2:0]      op;
        logic            alusrc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [4:0]      rd;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            is_branch;
        logic            branch_ne;
    } idex_t;

    // A bubble clears every field, so the op code reads as add.
    localparam idex_t BUBBLE = '0;

    // Instruction fields.
    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_field_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_s_s;
    logic [XLEN-1:0] imm_b_s;

    // The rs1 field is read by the register file, not by this block.
    logic            unused_rs1_s;

    // Decoder result and pipeline register.
    idex_t           dec_s;
    logic            dec_legal_s;
    idex_t           idex_nxt_s;
    idex_t           idex_r;
    logic            illegal_nxt_s;
    logic            illegal_r;
    logic            branch_taken_s;
    logic [CNT_W-1:0] cnt_r;

    assign opcode_s     = id_instr[6:0];
    assign funct3_s     = id_instr[14:12];
    assign funct7_s     = id_instr[31:25];
    assign rd_field_s   = id_instr[11:7];
    assign unused_rs1_s = ^id_instr[19:15];

    // Sign-extended immediates; the B-immediate always has bit 0 clear.
    assign imm_i_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
    assign imm_s_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b_s = {{(XLEN-12){id_instr[31]}}, id_instr[7], id_instr[30:25],
                      id_instr[11:8], 1'b0};

    // Decode the ID instruction into ALU op, operand select and controls.
    always_comb begin
        dec_s       = BUBBLE;
        dec_legal_s = 1'b0;
        dec_s.valid = 1'b1;
        dec_s.pc    = id_pc;
        case (opcode_s)
            OPC_OP: begin
                dec_s.rd       = rd_field_s;
                dec_s.regwrite = 1'b1;
                if (funct7_s == F7_BASE) begin
                    dec_legal_s = 1'b1;
                    case (funct3_s)
                        F3_ADD:  dec_s.op = ALU_ADD;
                        F3_AND:  dec_s.op = ALU_AND;
                        F3_OR:   dec_s.op = ALU_OR;
                        F3_SLT:  dec_s.op = ALU_SLT;
                        default: dec_legal_s = 1'b0;
                    endcase
                end else if ((funct7_s == F7_ALT) && (funct3_s == F3_ADD)) begin
                    dec_legal_s = 1'b1;
                    dec_s.op    = ALU_SUB;
                end else begin
                    dec_legal_s = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec_s.rd       = rd_field_s;
                dec_s.regwrite = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.imm      = imm_i_s;
                dec_legal_s    = 1'b1;
                case (funct3_s)
                    F3_ADD:  dec_s.op = ALU_ADD;
                    F3_AND:  dec_s.op = ALU_AND;
                    F3_OR:   dec_s.op = ALU_OR;
                    F3_SLT:  dec_s.op = ALU_SLT;
                    default: dec_legal_s = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_s.rd       = rd_field_s;
                dec_s.regwrite = 1'b1;
                dec_s.memread  = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.imm      = imm_i_s;
                dec_s.op       = ALU_ADD;
                dec_legal_s    = (funct3_s == F3_WORD);
            end
            OPC_STORE: begin
                dec_s.memwrite = 1'b1;
                dec_s.alusrc   = 1'b1;
                dec_s.imm      = imm_s_s;
                dec_s.op       = ALU_ADD;
                dec_legal_s    = (funct3_s == F3_WORD);
            end
            OPC_BRANCH: begin
                dec_s.is_branch = 1'b1;
                dec_s.branch_ne = funct3_s[0];
                dec_s.imm       = imm_b_s;
                dec_s.op        = ALU_SUB;
                dec_legal_s     = (funct3_s == F3_BEQ) || (funct3_s == F3_BNE);
            end
            default: begin
                dec_legal_s = 1'b0;
            end
        endcase
    end

    // Resolve the branch sitting in EX against the ALU zero flag.
    always_comb begin
        branch_taken_s = 1'b0;
        if (idex_r.valid && idex_r.is_branch) begin
            branch_taken_s = alu_zero ^ idex_r.branch_ne;
        end else begin
            branch_taken_s = 1'b0;
        end
    end

    // Next ID/EX contents: flush beats stall, stall beats a fresh load.
    always_comb begin
        idex_nxt_s    = idex_r;
        illegal_nxt_s = 1'b0;
        if (branch_taken_s) begin
            idex_nxt_s = BUBBLE;
        end else if (stall) begin
            idex_nxt_s = idex_r;
        end else if (id_valid) begin
            if (dec_legal_s) begin
                idex_nxt_s = dec_s;
            end else begin
                idex_nxt_s    = BUBBLE;
                illegal_nxt_s = 1'b1;
            end
        end else begin
            idex_nxt_s = BUBBLE;
        end
    end

    // ID/EX pipeline register and the one-cycle illegal-instruction pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_r    <= BUBBLE;
            illegal_r <= 1'b0;
        end else begin
            idex_r    <= idex_nxt_s;
            illegal_r <= illegal_nxt_s;
        end
    end

    // Taken-branch counter; wraps naturally and survives flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (branch_taken_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ex_valid        = idex_r.valid;
    assign ex_aluoperation = idex_r.op;
    assign ex_alusrc       = idex_r.alusrc;
    assign ex_imm          = idex_r.imm;
    assign ex_pc           = idex_r.pc;
    assign ex_rd           = idex_r.rd;
    assign ex_regwrite     = idex_r.regwrite;
    assign ex_memread      = idex_r.memread;
    assign ex_memwrite     = idex_r.memwrite;
    assign illegal_instr   = illegal_r;
    assign taken_count     = cnt_r;
    assign branch_taken    = branch_taken_s;
    assign branch_target   = idex_r.pc + idex_r.imm;

endmodule

// File: doc/alu_ctrl_idex.md
Name: alu_ctrl_idex

Overview:
- Issue-side counterpart of the EX-stage ALU in the 5-stage RV32I pipeline.
- Decodes the ID-stage instruction into the 3-bit ALU operation code and the datapath controls, and holds them in the ID/EX pipeline register.
- In EX, consumes the ALU zero flag to resolve BEQ/BNE and to request a front-end flush.
- Counts taken branches for performance monitoring.

Parameters:
- XLEN, 32, datapath width for pc, immediate and branch target.
- CNT_W, 16, width of the taken-branch counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_instr  in  32  ID-stage instruction word
- id_pc  in  XLEN  ID-stage pc
- stall  in  1  hazard unit hold; ID/EX register keeps its contents
- alu_zero  in  1  zero flag from the EX-stage ALU (same cycle)
- ex_valid  out  1  EX slot holds a real instruction
- ex_aluoperation  out  3  ALU op code: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ex_alusrc  out  1  1 selects ex_imm as ALU operand b
- ex_imm  out  XLEN  sign-extended immediate
- ex_pc  out  XLEN  pc of the EX instruction
- ex_rd  out  5  destination register
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  write-back and memory controls
- branch_taken  out  1  combinational: resolved taken branch in EX
- branch_target  out  XLEN  combinational: ex_pc + ex_imm
- illegal_instr  out  1  registered: unsupported encoding accepted this cycle
- taken_count  out  CNT_W  number of taken branches

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0. This makes ex_aluoperation = 000 (add), and EX holds a bubble.
- Decode on opcode id_instr[6:0]:
  - 0110011 R-type: funct3 000 → 000, or 001 if funct7[5]=1; 111 → 010; 110 → 011; 010 → 101. alusrc 0, regwrite 1.
  - 0010011 I-type: funct3 000 → 000; 111 → 010; 110 → 011; 010 → 101. alusrc 1, regwrite 1, I-immediate.
  - 0000011 LW: op 000, alusrc 1, memread 1, regwrite 1, I-immediate.
  - 0100011 SW: op 000, alusrc 1, memwrite 1, S-immediate.
  - 1100011 BEQ (funct3 000) / BNE (funct3 001): op 001, alusrc 0, B-immediate (bit 0 = 0). is_branch 1, branch_ne = funct3[0].
  - Any other opcode/funct3/funct7 combination is illegal: load a bubble and pulse illegal_instr for one cycle. Only when id_valid=1, stall=0 and no flush.
- Bubble: valid 0, regwrite, memread, memwrite, is_branch all 0, op 000. The remaining fields are don't-care but are held at 0.
- Register update priority, each rising clk:
  1. flush (branch_taken=1): load a bubble. The ID instruction is wrong-path, and the flush wins over stall.
  2. stall=1: hold every field.
  3. otherwise: load the decode of id_instr, or a bubble if id_valid=0.
- Latency: one cycle from ID acceptance to the ex_* outputs.
- Branch resolution:
  - branch_taken = ex_valid & is_branch & (alu_zero XOR branch_ne).
  - branch_target = ex_pc + ex_imm, modulo 2^XLEN (wraps, no overflow flag).
  - Both are combinational from registered state plus alu_zero.
- taken_count: increments by 1 on each clock where branch_taken=1; wraps from all-ones to 0.
- Reset mid-operation: a pending branch is dropped, with no count and no flush.
- A flush does not clear taken_count.

Test Plan:
- Reset: drive rst_n low mid-cycle with valid state loaded → all outputs 0 immediately, taken_count 0.
- R-type decode: SUB x3,x1,x2 (0x402081B3) with id_valid=1 → next cycle ex_aluoperation=001, alusrc 0, rd 3, regwrite 1. SLT (0x0020A1B3) → 101.
- I/S decode: ADDI x5,x0,-4 (0xFFC00293) → op 000, alusrc 1, ex_imm 0xFFFFFFFC. SW x2,8(x1) (0x0020A423) → memwrite 1, ex_imm 8, regwrite 0.
- Branch:
  - BEQ at pc 0x100 with offset −16, alu_zero=1 → branch_taken 1, target 0x000000F0, next cycle ex_valid 0, taken_count 1.
  - Same with alu_zero=0 → not taken.
  - BNE with alu_zero=0 → taken.
- Stall vs flush: stall=1 for 3 cycles → ex_* frozen. Stall=1 while a taken branch is in EX → the bubble is still loaded.
- Illegal and wrap: opcode 0x7F → illegal_instr one-cycle pulse, bubble. Preload taken_count near all-ones, then one more taken branch → wraps to 0.
